// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Width of the latency down-counter; holds values 0..mem_lat.
    function automatic int lat_w(input int mem_lat);
        return (mem_lat < 1) ? 1 : $clog2(mem_lat + 1);
    endfunction

endpackage

// File: rtl/mem_arb_lat_ctr.sv
// Loadable down-counter with a done flag; stops at zero and never wraps.
module mem_arb_lat_ctr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] cnt;

    // Load takes priority; decrement only while non-zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between instruction
// fetch and data requesters. Data has priority; optional IF starvation
// guard is enabled with the MEMARB_STARVE_GUARD_EN macro.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int            CW       = lat_w(MEM_LAT);
    localparam logic [CW-1:0] LAT_INIT = CW'(MEM_LAT - 1);

    state_t            state, state_nx;
    owner_t            owner_q;
    logic              store_done_q;
    logic              cnt_done;
    logic              wait_done;
    logic              if_pend, d_pend;
    logic              grant_if, grant_d;
    logic              force_if;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

    // A requester whose valid is pulsing this cycle still holds req; it must
    // not be granted again, so grants look at the stall terms, not raw req.
    assign if_pend   = if_req & ~if_valid;
    assign d_pend    = d_req & ~d_valid;
    assign stall_if  = if_pend;
    assign stall_mem = d_pend;

    assign wait_done = (state == ST_WAIT) && cnt_done;
    assign if_valid  = wait_done && (owner_q == OWN_IF);
    assign d_valid   = (wait_done && (owner_q == OWN_D)) || store_done_q;

    // Read data is valid on mem_rdata in the completion cycle, so it is
    // forwarded then and held in the owner register afterwards.
    assign if_rdata = if_valid ? mem_rdata : if_rdata_q;
    assign d_rdata  = (wait_done && (owner_q == OWN_D)) ? mem_rdata : d_rdata_q;

`ifdef MEMARB_STARVE_GUARD_EN
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_q;

    assign force_if = (starve_q == SW'(STARVE_LIMIT));

    // Count IF-denied decisions; clear on any IF grant, saturate at limit.
    always_ff @(posedge clk) begin
        if (reset || grant_if) begin
            starve_q <= '0;
        end else if (grant_d && if_pend && !force_if) begin
            starve_q <= starve_q + SW'(1);
        end
    end
`else
    assign force_if = 1'b0;
`endif

    mem_arb_lat_ctr #(.W(CW)) u_lat_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     ((state == ST_ISSUE) && !mem_we),
        .load_val (LAT_INIT),
        .dec      (state == ST_WAIT),
        .done     (cnt_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Grant decision and next-state logic.
    always_comb begin
        state_nx = state;
        grant_if = 1'b0;
        grant_d  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (d_pend && !(force_if && if_pend)) begin
                    grant_d  = 1'b1;
                    state_nx = ST_ISSUE;
                end else if (if_pend) begin
                    grant_if = 1'b1;
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nx = mem_we ? ST_IDLE : ST_WAIT;
            ST_WAIT:  if (cnt_done) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Memory request registers, owner tracking and read data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            owner_q      <= OWN_IF;
            store_done_q <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            mem_en       <= grant_if | grant_d;
            store_done_q <= (state == ST_ISSUE) && mem_we;
            if (grant_d) begin
                owner_q   <= OWN_D;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (grant_if) begin
                owner_q  <= OWN_IF;
                mem_we   <= 1'b0;
                mem_addr <= if_addr;
            end
            if (if_valid) begin
                if_rdata_q <= mem_rdata;
            end
            if (wait_done && (owner_q == OWN_D)) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

endmodule
